serial_nibble_loader: RTL and testbench

Upstream feeder for the 4-bit code converter. It accepts a serial bit stream MSB-first over a valid/ready handshake and assembles each group of 4 bits. Each completed nibble is presented as the converter's parallel inputs a,b,c,d with a valid/ready output handshake. It absorbs downstream backpressure and discards partial nibbles on an idle timeout.

---
 rtl/serial_nibble_loader.sv | 139 +++++++++++++
 tb/tb_serial_nibble_loader.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_nibble_loader.sv
`default_nettype none
// ============================================================================
// Module      : serial_nibble_loader
// Description : Assembles an MSB-first serial bit stream into 4-bit nibbles
//               presented as a,b,c,d over a valid/ready handshake, with one
//               nibble of backpressure buffering and an idle timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_nibble_loader #(
  parameter int TIMEOUT = 16,
  parameter int CW      = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         bit_in,
  input  logic         bit_valid,
  output logic         bit_ready,
  output logic         a,
  output logic         b,
  output logic         c,
  output logic         d,
  output logic         nib_valid,
  input  logic         nib_ready,
  output logic         abort,
  output logic [2:0]   bit_cnt
);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_shift = 2'd1;
  localparam logic [1:0] c_st_full  = 2'd2;

  localparam logic          c_tmo_en   = (TIMEOUT > 0);
  localparam logic [CW-1:0] c_tmo_last = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  logic [1:0]    r_state;
  logic [3:0]    r_sr;
  logic [2:0]    r_bit_cnt;
  logic [CW-1:0] r_idle_cnt;
  logic [3:0]    r_nibble;
  logic          r_nib_valid;
  logic          r_abort;

  logic          w_accept;
  logic          w_consume;
  logic          w_out_free;
  logic [3:0]    w_sr_next;
  logic          w_last_bit;

  assign bit_ready  = !rst && (r_state != c_st_full);
  assign w_accept   = bit_valid && bit_ready;
  assign w_consume  = r_nib_valid && nib_ready;
  // The output slot can take a new nibble if empty or being drained this edge.
  assign w_out_free = !r_nib_valid || w_consume;
  assign w_sr_next  = {r_sr[2:0], bit_in};
  assign w_last_bit = (r_bit_cnt == 3'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= c_st_idle;
      r_sr        <= 4'd0;
      r_bit_cnt   <= 3'd0;
      r_idle_cnt  <= '0;
      r_nibble    <= 4'd0;
      r_nib_valid <= 1'b0;
      r_abort     <= 1'b0;
    end else begin
      r_abort <= 1'b0;
      if (w_consume) begin
        r_nib_valid <= 1'b0;
      end

      case (r_state)
        c_st_idle, c_st_shift: begin
          if (w_accept) begin
            r_idle_cnt <= '0;
            if (w_last_bit) begin
              if (w_out_free) begin
                r_nibble    <= w_sr_next;
                r_nib_valid <= 1'b1;
                r_sr        <= 4'd0;
                r_bit_cnt   <= 3'd0;
                r_state     <= c_st_idle;
              end else begin
                r_sr        <= w_sr_next;
                r_bit_cnt   <= 3'd4;
                r_state     <= c_st_full;
              end
            end else begin
              r_sr      <= w_sr_next;
              r_bit_cnt <= r_bit_cnt + 3'd1;
              r_state   <= c_st_shift;
            end
          end else if ((r_state == c_st_shift) && c_tmo_en) begin
            if (r_idle_cnt == c_tmo_last) begin
              r_sr       <= 4'd0;
              r_bit_cnt  <= 3'd0;
              r_idle_cnt <= '0;
              r_abort    <= 1'b1;
              r_state    <= c_st_idle;
            end else if (r_idle_cnt != '1) begin
              r_idle_cnt <= r_idle_cnt + 1'b1;
            end
          end else begin
            r_idle_cnt <= '0;
          end
        end

        c_st_full: begin
          r_idle_cnt <= '0;
          // Held nibble moves out on the consuming edge, keeping nib_valid high.
          if (w_consume) begin
            r_nibble    <= r_sr;
            r_nib_valid <= 1'b1;
            r_sr        <= 4'd0;
            r_bit_cnt   <= 3'd0;
            r_state     <= c_st_idle;
          end
        end

        default: begin
          r_state    <= c_st_idle;
          r_sr       <= 4'd0;
          r_bit_cnt  <= 3'd0;
          r_idle_cnt <= '0;
        end
      endcase
    end
  end

  assign a         = r_nibble[3];
  assign b         = r_nibble[2];
  assign c         = r_nibble[1];
  assign d         = r_nibble[0];
  assign nib_valid = r_nib_valid;
  assign abort     = r_abort;
  assign bit_cnt   = r_bit_cnt;

endmodule
`default_nettype wire

// File: tb/tb_serial_nibble_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_nibble_loader
// Description : Directed self-checking bench for serial_nibble_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_nibble_loader;

  logic       clk;
  logic       rst;
  logic       bit_in;
  logic       bit_valid;
  logic       bit_ready;
  logic       a, b, c, d;
  logic       nib_valid;
  logic       nib_ready;
  logic       abort;
  logic [2:0] bit_cnt;

  int total = 0;
  int bad   = 0;

  serial_nibble_loader #(.TIMEOUT(8), .CW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .nib_valid (nib_valid),
    .nib_ready (nib_ready),
    .abort     (abort),
    .bit_cnt   (bit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; results are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic v);
    bit_valid = 1'b1;
    bit_in    = v;
    tick();
  endtask

  function automatic logic [3:0] abcd();
    return {a, b, c, d};
  endfunction

  initial begin
    logic [3:0] n;
    rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; nib_ready = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_abcd", {28'd0, abcd()}, 32'h0);
    chk("rst_nib_valid", {31'd0, nib_valid}, 32'd0);
    chk("rst_abort", {31'd0, abort}, 32'd0);
    chk("rst_bit_cnt", {29'd0, bit_cnt}, 32'd0);
    chk("rst_bit_ready", {31'd0, bit_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_bit_ready", {31'd0, bit_ready}, 32'd1);

    // 1011 with nib_ready high
    nib_ready = 1'b1;
    send(1'b1); chk("t1_cnt1", {29'd0, bit_cnt}, 32'd1);
    send(1'b0); chk("t1_cnt2", {29'd0, bit_cnt}, 32'd2);
    send(1'b1); chk("t1_cnt3", {29'd0, bit_cnt}, 32'd3);
    chk("t1_nv_before", {31'd0, nib_valid}, 32'd0);
    send(1'b1);
    chk("t1_cnt0", {29'd0, bit_cnt}, 32'd0);
    chk("t1_nv", {31'd0, nib_valid}, 32'd1);
    chk("t1_abcd", {28'd0, abcd()}, 32'hB);
    bit_valid = 1'b0;
    tick();
    chk("t1_nv_drop", {31'd0, nib_valid}, 32'd0);
    chk("t1_abcd_keep", {28'd0, abcd()}, 32'hB);

    // All 16 nibbles back to back
    for (int k = 0; k < 16; k++) begin
      n = 4'(k);
      for (int i = 3; i >= 0; i--) begin
        send(n[i]);
        chk("t2_bit_ready", {31'd0, bit_ready}, 32'd1);
        if (i == 0) begin
          chk("t2_nv", {31'd0, nib_valid}, 32'd1);
          chk("t2_abcd", {28'd0, abcd()}, {28'd0, n});
        end else begin
          chk("t2_nv_low", {31'd0, nib_valid}, 32'd0);
        end
      end
    end
    bit_valid = 1'b0;
    tick();

    // Backpressure: 0101 presented, 0011 held
    nib_ready = 1'b0;
    send(1'b0); send(1'b1); send(1'b0); send(1'b1);
    chk("t3_nv", {31'd0, nib_valid}, 32'd1);
    chk("t3_abcd", {28'd0, abcd()}, 32'h5);
    send(1'b0); send(1'b0); send(1'b1); send(1'b1);
    chk("t3_bit_ready", {31'd0, bit_ready}, 32'd0);
    chk("t3_cnt4", {29'd0, bit_cnt}, 32'd4);
    chk("t3_abcd_stable", {28'd0, abcd()}, 32'h5);

    // Bits offered while FULL are ignored
    for (int i = 0; i < 3; i++) begin
      send(1'(i));
      chk("t7_cnt4", {29'd0, bit_cnt}, 32'd4);
      chk("t7_abcd", {28'd0, abcd()}, 32'h5);
      chk("t7_bit_ready", {31'd0, bit_ready}, 32'd0);
    end
    bit_valid = 1'b0;

    // One-cycle nib_ready releases the held nibble with no bubble
    nib_ready = 1'b1;
    tick();
    nib_ready = 1'b0;
    chk("t4_abcd", {28'd0, abcd()}, 32'h3);
    chk("t4_nv", {31'd0, nib_valid}, 32'd1);
    chk("t4_cnt0", {29'd0, bit_cnt}, 32'd0);
    chk("t4_bit_ready", {31'd0, bit_ready}, 32'd1);
    tick();
    chk("t4_nv_hold", {31'd0, nib_valid}, 32'd1);
    chk("t4_abcd_hold", {28'd0, abcd()}, 32'h3);

    // Consume and 4th-bit accept on the same edge
    send(1'b0); send(1'b1); send(1'b1);
    nib_ready = 1'b1;
    send(1'b1);
    chk("t8_abcd", {28'd0, abcd()}, 32'h7);
    chk("t8_nv", {31'd0, nib_valid}, 32'd1);
    chk("t8_cnt0", {29'd0, bit_cnt}, 32'd0);
    chk("t8_bit_ready", {31'd0, bit_ready}, 32'd1);
    bit_valid = 1'b0;
    tick();
    chk("t8_nv_drop", {31'd0, nib_valid}, 32'd0);

    // Timeout after 8 idle cycles
    send(1'b1); send(1'b1);
    bit_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("t5_no_abort", {31'd0, abort}, 32'd0);
    end
    chk("t5_cnt2", {29'd0, bit_cnt}, 32'd2);
    tick();
    chk("t5_abort", {31'd0, abort}, 32'd1);
    chk("t5_cnt0", {29'd0, bit_cnt}, 32'd0);
    chk("t5_nv_unaff", {31'd0, nib_valid}, 32'd0);
    chk("t5_abcd_unaff", {28'd0, abcd()}, 32'h7);
    tick();
    chk("t5_abort_once", {31'd0, abort}, 32'd0);
    send(1'b0); send(1'b0); send(1'b0); send(1'b1);
    chk("t5_abcd", {28'd0, abcd()}, 32'h1);
    chk("t5_nv", {31'd0, nib_valid}, 32'd1);
    bit_valid = 1'b0;
    tick();

    // Mid-nibble reset
    send(1'b1); send(1'b1); send(1'b0);
    chk("t6_cnt3", {29'd0, bit_cnt}, 32'd3);
    bit_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("t6_bit_ready_rst", {31'd0, bit_ready}, 32'd0);
    tick();
    chk("t6_abcd", {28'd0, abcd()}, 32'h0);
    chk("t6_cnt", {29'd0, bit_cnt}, 32'd0);
    chk("t6_nv", {31'd0, nib_valid}, 32'd0);
    chk("t6_abort", {31'd0, abort}, 32'd0);
    chk("t6_bit_ready_in", {31'd0, bit_ready}, 32'd0);
    rst = 1'b0;
    send(1'b1); send(1'b1); send(1'b1); send(1'b0);
    chk("t6_abcd_new", {28'd0, abcd()}, 32'hE);
    chk("t6_nv_new", {31'd0, nib_valid}, 32'd1);
    bit_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
